cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: control sequencer for a small 8-bit CPU.
// It walks the reset vector, fetches opcodes, and steps through IMPLIED, IMM,
// ABS_LD, ABS_ST and JMP_ABS instruction timing.
// All outputs are a combinational decode of the current state, the decoder
// inputs (or their captured copies) and rdy.
// Handshake: rdy is the memory's valid/ready reply to a read cycle
// (mem_read=1). rdy=1 completes the read: strobes fire and the state advances.
// rdy=0 holds the state and the address and suppresses every strobe.
// Cycles without a read (mem_read=0) never wait on rdy.
module cpu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  input  logic [2:0] op_class,
  input  logic [1:0] op_dst,
  input  logic       op_alu,
  output logic       mem_read,
  output logic [1:0] addr_sel,
  output logic       vec_hi,
  output logic       IR_ld,
  output logic       PCL_ld,
  output logic       PCH_ld,
  output logic       pc_inc,
  output logic       DL_ld,
  output logic       DH_ld,
  output logic       alu_en,
  output logic       store_en,
  output logic       pcl_src,
  output logic [2:0] reg_ld,
  output logic       sync,
  output logic       illegal,
  output logic [2:0] t_state
);

  typedef enum logic [2:0] {
    RV_L   = 3'd0,
    RV_H   = 3'd1,
    FETCH  = 3'd2,
    DECODE = 3'd3,
    ADDR_H = 3'd4,
    EXEC   = 3'd5,
    LOAD   = 3'd6,
    STORE  = 3'd7
  } state_t;

  localparam logic [2:0] C_IMPLIED = 3'b000;
  localparam logic [2:0] C_IMM     = 3'b001;
  localparam logic [2:0] C_ABS_LD  = 3'b010;
  localparam logic [2:0] C_ABS_ST  = 3'b011;
  localparam logic [2:0] C_JMP_ABS = 3'b100;

  state_t     state;
  state_t     next_state;
  logic [2:0] cls_q;
  logic [1:0] dst_q;
  logic       alu_q;

  // Destination code to one-hot register load; code 11 loads nothing.
  function automatic logic [2:0] dst_onehot(input logic [1:0] dst);
    case (dst)
      2'b00:   dst_onehot = 3'b001;
      2'b01:   dst_onehot = 3'b010;
      2'b10:   dst_onehot = 3'b100;
      default: dst_onehot = 3'b000;
    endcase
  endfunction

  // State register and capture of the decoder fields while in DECODE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RV_L;
      cls_q <= 3'b000;
      dst_q <= 2'b00;
      alu_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == DECODE) begin
        cls_q <= op_class;
        dst_q <= op_dst;
        alu_q <= op_alu;
      end
    end
  end

  // Output decode and next-state logic, with stall and reset gating applied last.
  always_comb begin
    next_state = state;
    mem_read   = 1'b0;
    addr_sel   = 2'b00;
    vec_hi     = 1'b0;
    IR_ld      = 1'b0;
    PCL_ld     = 1'b0;
    PCH_ld     = 1'b0;
    pc_inc     = 1'b0;
    DL_ld      = 1'b0;
    DH_ld      = 1'b0;
    alu_en     = 1'b0;
    store_en   = 1'b0;
    pcl_src    = 1'b0;
    reg_ld     = 3'b000;
    sync       = 1'b0;
    illegal    = 1'b0;
    t_state    = state;

    case (state)
      RV_L: begin
        mem_read   = 1'b1;
        addr_sel   = 2'b10;
        PCL_ld     = 1'b1;
        next_state = RV_H;
      end
      RV_H: begin
        mem_read   = 1'b1;
        addr_sel   = 2'b10;
        vec_hi     = 1'b1;
        PCH_ld     = 1'b1;
        next_state = FETCH;
      end
      FETCH: begin
        mem_read   = 1'b1;
        IR_ld      = 1'b1;
        pc_inc     = 1'b1;
        sync       = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        case (op_class)
          C_IMPLIED: begin
            reg_ld     = dst_onehot(op_dst);
            alu_en     = op_alu;
            next_state = FETCH;
          end
          C_IMM: begin
            mem_read   = 1'b1;
            DL_ld      = 1'b1;
            pc_inc     = 1'b1;
            next_state = EXEC;
          end
          C_ABS_LD, C_ABS_ST, C_JMP_ABS: begin
            mem_read   = 1'b1;
            DL_ld      = 1'b1;
            pc_inc     = 1'b1;
            next_state = ADDR_H;
          end
          default: begin
            illegal    = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      ADDR_H: begin
        mem_read = 1'b1;
        pc_inc   = 1'b1;
        case (cls_q)
          C_ABS_LD: begin
            DH_ld      = 1'b1;
            next_state = LOAD;
          end
          C_ABS_ST: begin
            DH_ld      = 1'b1;
            next_state = STORE;
          end
          C_JMP_ABS: begin
            // High byte comes off the bus, low byte from DL: PC is replaced, not bumped.
            PCH_ld     = 1'b1;
            PCL_ld     = 1'b1;
            pcl_src    = 1'b1;
            pc_inc     = 1'b0;
            next_state = FETCH;
          end
          default: next_state = FETCH;
        endcase
      end
      EXEC: begin
        reg_ld     = dst_onehot(dst_q);
        alu_en     = alu_q;
        next_state = FETCH;
      end
      LOAD: begin
        mem_read   = 1'b1;
        addr_sel   = 2'b01;
        reg_ld     = dst_onehot(dst_q);
        alu_en     = alu_q;
        next_state = FETCH;
      end
      STORE: begin
        addr_sel   = 2'b01;
        store_en   = 1'b1;
        next_state = FETCH;
      end
      default: next_state = RV_L;
    endcase

    // A read waiting on memory: hold state and address, drop all strobes.
    // sync is only ever set in FETCH, so it is left as decoded.
    if (mem_read && !rdy) begin
      next_state = state;
      IR_ld      = 1'b0;
      PCL_ld     = 1'b0;
      PCH_ld     = 1'b0;
      pc_inc     = 1'b0;
      DL_ld      = 1'b0;
      DH_ld      = 1'b0;
      alu_en     = 1'b0;
      store_en   = 1'b0;
      pcl_src    = 1'b0;
      reg_ld     = 3'b000;
    end

    // Reset held low: everything visible is quiet, including t_state.
    if (!rst_n) begin
      mem_read = 1'b0;
      addr_sel = 2'b00;
      vec_hi   = 1'b0;
      IR_ld    = 1'b0;
      PCL_ld   = 1'b0;
      PCH_ld   = 1'b0;
      pc_inc   = 1'b0;
      DL_ld    = 1'b0;
      DH_ld    = 1'b0;
      alu_en   = 1'b0;
      store_en = 1'b0;
      pcl_src  = 1'b0;
      reg_ld   = 3'b000;
      sync     = 1'b0;
      illegal  = 1'b0;
      t_state  = 3'd0;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a cycle-by-cycle table of inputs and hand-derived
// outputs, followed by a short hand-written DECODE stall sequence.
module tb_cpu_sequencer;

  logic       clk;
  logic       rst_n;
  logic       rdy;
  logic [2:0] op_class;
  logic [1:0] op_dst;
  logic       op_alu;
  logic       mem_read;
  logic [1:0] addr_sel;
  logic       vec_hi;
  logic       IR_ld, PCL_ld, PCH_ld, pc_inc, DL_ld, DH_ld, alu_en, store_en;
  logic       pcl_src;
  logic [2:0] reg_ld;
  logic       sync;
  logic       illegal;
  logic [2:0] t_state;

  int n_cmp;
  int n_bad;

  // Expected output packing: mem_read, addr_sel, vec_hi,
  // {IR,PCL,PCH,pc_inc,DL,DH,alu,store}, pcl_src, reg_ld, sync, illegal, t_state
  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic [2:0]  cls;
    logic [1:0]  dst;
    logic        alu;
    logic [20:0] exp;
  } vec_t;

  vec_t tbl[$];

  cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .op_class(op_class), .op_dst(op_dst),
    .op_alu(op_alu), .mem_read(mem_read), .addr_sel(addr_sel), .vec_hi(vec_hi),
    .IR_ld(IR_ld), .PCL_ld(PCL_ld), .PCH_ld(PCH_ld), .pc_inc(pc_inc),
    .DL_ld(DL_ld), .DH_ld(DH_ld), .alu_en(alu_en), .store_en(store_en),
    .pcl_src(pcl_src), .reg_ld(reg_ld), .sync(sync), .illegal(illegal),
    .t_state(t_state)
  );

  // Clock and initial reset levels
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] mk(input logic mr, input logic [1:0] as,
                                     input logic vh, input logic [7:0] st,
                                     input logic ps, input logic [2:0] rl,
                                     input logic sy, input logic il,
                                     input logic [2:0] ts);
    mk = {mr, as, vh, st, ps, rl, sy, il, ts};
  endfunction

  function automatic logic [20:0] actual();
    actual = {mem_read, addr_sel, vec_hi,
              IR_ld, PCL_ld, PCH_ld, pc_inc, DL_ld, DH_ld, alu_en, store_en,
              pcl_src, reg_ld, sync, illegal, t_state};
  endfunction

  task automatic add(input logic r, input logic y, input logic [2:0] c,
                     input logic [1:0] d, input logic a, input logic [20:0] e);
    vec_t v;
    v.rst_n = r; v.rdy = y; v.cls = c; v.dst = d; v.alu = a; v.exp = e;
    tbl.push_back(v);
  endtask

  // Driver: apply inputs on the falling edge, compare mid-low-phase.
  task automatic step(input string name, input logic r, input logic y,
                      input logic [2:0] c, input logic [1:0] d, input logic a,
                      input logic [20:0] e);
    logic [20:0] got;
    @(negedge clk);
    rst_n = r; rdy = y; op_class = c; op_dst = d; op_alu = a;
    #2;
    got = actual();
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t_state got %0d exp %0d)",
               name, got, e, got[2:0], e[2:0]);
    end
  endtask

  localparam logic [7:0] S_NONE  = 8'b0000_0000;
  localparam logic [7:0] S_PCL   = 8'b0100_0000;
  localparam logic [7:0] S_PCH   = 8'b0010_0000;
  localparam logic [7:0] S_FETCH = 8'b1001_0000;
  localparam logic [7:0] S_DLINC = 8'b0001_1000;
  localparam logic [7:0] S_DHINC = 8'b0001_0100;
  localparam logic [7:0] S_JMP   = 8'b0110_0000;
  localparam logic [7:0] S_ALU   = 8'b0000_0010;
  localparam logic [7:0] S_STORE = 8'b0000_0001;

  initial begin
    logic [20:0] e_fetch;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0; rdy = 1'b1; op_class = 3'b000; op_dst = 2'b00; op_alu = 1'b0;
    repeat (2) @(posedge clk);

    e_fetch = mk(1, 2'b00, 0, S_FETCH, 0, 3'b000, 1, 0, 3'd2);

    // reset held, then vector fetch
    add(0, 1, 3'b000, 2'b00, 0, mk(0, 2'b00, 0, S_NONE, 0, 3'b000, 0, 0, 3'd0));
    add(1, 1, 3'b000, 2'b00, 0, mk(1, 2'b10, 0, S_PCL,  0, 3'b000, 0, 0, 3'd0));
    add(1, 1, 3'b000, 2'b00, 0, mk(1, 2'b10, 1, S_PCH,  0, 3'b000, 0, 0, 3'd1));
    add(1, 1, 3'b000, 2'b00, 0, e_fetch);
    // IMM, dst X; EXEC sees a different live op_class/op_dst
    add(1, 1, 3'b001, 2'b01, 0, mk(1, 2'b00, 0, S_DLINC, 0, 3'b000, 0, 0, 3'd3));
    add(1, 1, 3'b000, 2'b10, 0, mk(0, 2'b00, 0, S_NONE,  0, 3'b010, 0, 0, 3'd5));
    add(1, 1, 3'b000, 2'b00, 0, e_fetch);
    // ABS_ST, rdy low in STORE
    add(1, 1, 3'b011, 2'b00, 0, mk(1, 2'b00, 0, S_DLINC, 0, 3'b000, 0, 0, 3'd3));
    add(1, 1, 3'b000, 2'b00, 0, mk(1, 2'b00, 0, S_DHINC, 0, 3'b000, 0, 0, 3'd4));
    add(1, 0, 3'b000, 2'b00, 0, mk(0, 2'b01, 0, S_STORE, 0, 3'b000, 0, 0, 3'd7));
    add(1, 1, 3'b000, 2'b00, 0, e_fetch);
    // JMP_ABS, then one stalled FETCH
    add(1, 1, 3'b100, 2'b00, 0, mk(1, 2'b00, 0, S_DLINC, 0, 3'b000, 0, 0, 3'd3));
    add(1, 1, 3'b000, 2'b00, 0, mk(1, 2'b00, 0, S_JMP,   1, 3'b000, 0, 0, 3'd4));
    add(1, 0, 3'b000, 2'b00, 0, mk(1, 2'b00, 0, S_NONE,  0, 3'b000, 1, 0, 3'd2));
    add(1, 1, 3'b000, 2'b00, 0, e_fetch);
    // IMPLIED dst Y through ALU, rdy low has no effect
    add(1, 0, 3'b000, 2'b10, 1, mk(0, 2'b00, 0, S_ALU,   0, 3'b100, 0, 0, 3'd3));
    add(1, 1, 3'b000, 2'b00, 0, e_fetch);
    // ABS_LD dst A, LOAD stalled three cycles
    add(1, 1, 3'b010, 2'b00, 0, mk(1, 2'b00, 0, S_DLINC, 0, 3'b000, 0, 0, 3'd3));
    add(1, 1, 3'b000, 2'b11, 0, mk(1, 2'b00, 0, S_DHINC, 0, 3'b000, 0, 0, 3'd4));
    add(1, 0, 3'b000, 2'b11, 0, mk(1, 2'b01, 0, S_NONE,  0, 3'b000, 0, 0, 3'd6));
    add(1, 0, 3'b000, 2'b11, 0, mk(1, 2'b01, 0, S_NONE,  0, 3'b000, 0, 0, 3'd6));
    add(1, 0, 3'b000, 2'b11, 0, mk(1, 2'b01, 0, S_NONE,  0, 3'b000, 0, 0, 3'd6));
    add(1, 1, 3'b000, 2'b11, 0, mk(1, 2'b01, 0, S_NONE,  0, 3'b001, 0, 0, 3'd6));
    add(1, 1, 3'b000, 2'b00, 0, e_fetch);
    // reserved class
    add(1, 1, 3'b110, 2'b00, 1, mk(0, 2'b00, 0, S_NONE,  0, 3'b000, 0, 1, 3'd3));
    add(1, 1, 3'b000, 2'b00, 0, e_fetch);
    // IMPLIED with dst none
    add(1, 1, 3'b000, 2'b11, 0, mk(0, 2'b00, 0, S_NONE,  0, 3'b000, 0, 0, 3'd3));
    add(1, 1, 3'b000, 2'b00, 0, e_fetch);
    // reset asserted in ADDR_H, then stalled and normal vector fetch
    add(1, 1, 3'b010, 2'b01, 0, mk(1, 2'b00, 0, S_DLINC, 0, 3'b000, 0, 0, 3'd3));
    add(0, 1, 3'b000, 2'b00, 0, mk(0, 2'b00, 0, S_NONE,  0, 3'b000, 0, 0, 3'd0));
    add(1, 0, 3'b000, 2'b00, 0, mk(1, 2'b10, 0, S_NONE,  0, 3'b000, 0, 0, 3'd0));
    add(1, 1, 3'b000, 2'b00, 0, mk(1, 2'b10, 0, S_PCL,   0, 3'b000, 0, 0, 3'd0));
    add(1, 1, 3'b000, 2'b00, 0, mk(1, 2'b10, 1, S_PCH,   0, 3'b000, 0, 0, 3'd1));
    add(1, 1, 3'b000, 2'b00, 0, e_fetch);

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].rdy, tbl[i].cls,
           tbl[i].dst, tbl[i].alu, tbl[i].exp);
    end

    // Hand sequence: IMM DECODE waits two cycles on rdy, EXEC uses captured dst Y.
    step("dec_stall1", 1, 0, 3'b001, 2'b10, 0, mk(1, 2'b00, 0, S_NONE,  0, 3'b000, 0, 0, 3'd3));
    step("dec_stall2", 1, 0, 3'b001, 2'b10, 0, mk(1, 2'b00, 0, S_NONE,  0, 3'b000, 0, 0, 3'd3));
    step("dec_go",     1, 1, 3'b001, 2'b10, 0, mk(1, 2'b00, 0, S_DLINC, 0, 3'b000, 0, 0, 3'd3));
    step("exec_y",     1, 0, 3'b000, 2'b00, 0, mk(0, 2'b00, 0, S_NONE,  0, 3'b100, 0, 0, 3'd5));
    step("fetch_after",1, 1, 3'b000, 2'b00, 0, e_fetch);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
